// File: rtl/mii_pkg.sv
// Shared constants and state type for the 64-bit MII receive checker.
// Holds XGMII control characters, preamble/SFD bytes, lane count and FSM states.
package mii_pkg;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERROR = 8'hFE;
    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD      = 8'hD5;

    localparam int LANES = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_e;

endpackage

// File: rtl/mii_term_locator.sv
// Combinational lane scan: finds the first control lane of a 64-bit beat.
// Ports: c_i/d_i beat in; idx_o, any_ctrl_o, is_term_o, tail_ok_o, data_mask_o out.
module mii_term_locator
    import mii_pkg::*;
(
    input  logic [7:0]  c_i,
    input  logic [63:0] d_i,
    output logic [2:0]  idx_o,
    output logic        any_ctrl_o,
    output logic        is_term_o,
    output logic        tail_ok_o,
    output logic [7:0]  data_mask_o
);

    logic       found;
    logic [7:0] lane;

    always_comb begin
        idx_o       = '0;
        found       = 1'b0;
        tail_ok_o   = 1'b1;
        data_mask_o = '0;
        lane        = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = d_i[8*i +: 8];
            if (found) begin
                if (!(c_i[i] && lane == CH_IDLE)) begin
                    tail_ok_o = 1'b0;
                end
            end else if (c_i[i]) begin
                found = 1'b1;
                idx_o = 3'(i);
            end else begin
                data_mask_o[i] = 1'b1;
            end
        end
    end

    assign any_ctrl_o = found;
    assign is_term_o  = found && (d_i[8*idx_o +: 8] == CH_TERM);

endmodule

// File: rtl/mii_rx_checker.sv
// Self-checking MII receive sink: parses frames, checks payload and length.
// Ports: clk, i_rst_n, i_valid, i_mii_rx_d/c in; per-frame flags, len, counters out.
module mii_rx_checker
    import mii_pkg::*;
#(
    parameter int         PAYLOAD_MAX_SIZE     = 1500,
    parameter logic [7:0] PAYLOAD_CHAR_PATTERN = 8'h55,
    parameter int         PAYLOAD_LENGTH       = 58,
    parameter int         LEN_W = $clog2(PAYLOAD_MAX_SIZE + 8) + 1
)(
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [63:0]      i_mii_rx_d,
    input  logic [7:0]       i_mii_rx_c,
    output logic             o_frame_done,
    output logic [LEN_W-1:0] o_frame_len,
    output logic             o_hdr_err,
    output logic             o_pat_err,
    output logic             o_len_err,
    output logic             o_ctrl_err,
    output logic             o_in_frame,
    output logic [31:0]      o_frame_cnt,
    output logic [31:0]      o_err_cnt
);

    // Oversize frames park the count one above the legal maximum.
    localparam logic [LEN_W:0] LEN_CAP = (LEN_W + 1)'(PAYLOAD_MAX_SIZE + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             hdr_q, hdr_d, pat_q, pat_d;
    logic             lerr_q, lerr_d, ctrl_q, ctrl_d;

    logic             done_q;
    logic [LEN_W-1:0] flen_q;
    logic             fhdr_q, fpat_q, flerr_q, fctrl_q;
    logic [31:0]      frame_cnt_q, err_cnt_q;

    logic [2:0]       idx;
    logic             any_ctrl, is_term, tail_ok;
    logic [7:0]       data_mask;

    mii_term_locator u_loc (
        .c_i         (i_mii_rx_c),
        .d_i         (i_mii_rx_d),
        .idx_o       (idx),
        .any_ctrl_o  (any_ctrl),
        .is_term_o   (is_term),
        .tail_ok_o   (tail_ok),
        .data_mask_o (data_mask)
    );

    logic [7:0] pat_ne;
    logic [7:0] lane;
    logic       any_fd, all_idle, hdr_bad, is_start, pat_hit;

    always_comb begin
        pat_ne   = '0;
        any_fd   = 1'b0;
        all_idle = (i_mii_rx_c == 8'hFF);
        lane     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane      = i_mii_rx_d[8*i +: 8];
            pat_ne[i] = (lane != PAYLOAD_CHAR_PATTERN);
            if (i_mii_rx_c[i] && lane == CH_TERM) any_fd = 1'b1;
            if (lane != CH_IDLE) all_idle = 1'b0;
        end
    end

    assign is_start = i_mii_rx_c[0] && (i_mii_rx_d[7:0] == CH_START);
    assign hdr_bad  = (i_mii_rx_c != 8'h01)
                   || (i_mii_rx_d[55:8] != {6{PREAMBLE}})
                   || (i_mii_rx_d[63:56] != SFD);
    // Mask is all ones on a pure data beat, lanes below the control lane otherwise.
    assign pat_hit  = |(pat_ne & data_mask);

    logic [LEN_W:0]   add_n, sum;
    logic             over;
    logic [LEN_W-1:0] len_sat;

    assign add_n   = any_ctrl ? (LEN_W + 1)'(idx) : (LEN_W + 1)'(8);
    assign sum     = {1'b0, len_q} + add_n;
    assign over    = (sum > LEN_CAP - 1'b1);
    assign len_sat = over ? LEN_CAP[LEN_W-1:0] : sum[LEN_W-1:0];

    logic             close;
    logic [LEN_W-1:0] cl_len;
    logic             cl_hdr, cl_pat, cl_lerr, cl_ctrl, cl_lerr_f, cl_any;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hdr_d   = hdr_q;
        pat_d   = pat_q;
        lerr_d  = lerr_q;
        ctrl_d  = ctrl_q;
        close   = 1'b0;
        cl_len  = len_q;
        cl_hdr  = hdr_q;
        cl_pat  = pat_q;
        cl_lerr = lerr_q;
        cl_ctrl = ctrl_q;
        if (i_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_start) begin
                        state_d = S_DATA;
                        len_d   = '0;
                        hdr_d   = hdr_bad;
                        pat_d   = 1'b0;
                        lerr_d  = 1'b0;
                        ctrl_d  = 1'b0;
                    end
                end
                S_DATA: begin
                    if (is_start) begin
                        // Close the truncated frame, then reopen on this beat.
                        close   = 1'b1;
                        cl_ctrl = 1'b1;
                        len_d   = '0;
                        hdr_d   = hdr_bad;
                        pat_d   = 1'b0;
                        lerr_d  = 1'b0;
                        ctrl_d  = 1'b0;
                    end else if (!any_ctrl || is_term) begin
                        len_d  = len_sat;
                        pat_d  = pat_q | pat_hit;
                        lerr_d = lerr_q | over;
                        if (is_term) begin
                            ctrl_d  = ctrl_q | !tail_ok;
                            close   = 1'b1;
                            cl_len  = len_sat;
                            cl_pat  = pat_q | pat_hit;
                            cl_lerr = lerr_q | over;
                            cl_ctrl = ctrl_q | !tail_ok;
                            state_d = S_IDLE;
                        end else if (over) begin
                            state_d = S_DROP;
                        end
                    end else begin
                        ctrl_d  = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_DROP: begin
                    if (any_fd || all_idle) begin
                        close   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cl_lerr_f = cl_lerr || (cl_len != LEN_W'(PAYLOAD_LENGTH));
    assign cl_any    = cl_hdr || cl_pat || cl_lerr_f || cl_ctrl;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            hdr_q       <= 1'b0;
            pat_q       <= 1'b0;
            lerr_q      <= 1'b0;
            ctrl_q      <= 1'b0;
            done_q      <= 1'b0;
            flen_q      <= '0;
            fhdr_q      <= 1'b0;
            fpat_q      <= 1'b0;
            flerr_q     <= 1'b0;
            fctrl_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hdr_q   <= hdr_d;
            pat_q   <= pat_d;
            lerr_q  <= lerr_d;
            ctrl_q  <= ctrl_d;
            done_q  <= close;
            if (close) begin
                flen_q      <= cl_len;
                fhdr_q      <= cl_hdr;
                fpat_q      <= cl_pat;
                flerr_q     <= cl_lerr_f;
                fctrl_q     <= cl_ctrl;
                frame_cnt_q <= frame_cnt_q + 32'd1;
                if (cl_any) err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign o_frame_done = done_q;
    assign o_frame_len  = flen_q;
    assign o_hdr_err    = fhdr_q;
    assign o_pat_err    = fpat_q;
    assign o_len_err    = flerr_q;
    assign o_ctrl_err   = fctrl_q;
    assign o_in_frame   = (state_q != S_IDLE);
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err_cnt    = err_cnt_q;

endmodule
